sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 clear_n  input  1  reset, synchronous, active-low.
REQ-004 sin  input  1  serial data bit.
REQ-005 sin_en  input  1  bit strobe; sin is sampled on a rising clk edge only when sin_en=1.
REQ-006 flush  input  1  synchronous abort of the partial word.
REQ-007 dout  output  WIDTH  deserialized word from the holding register.
REQ-008 dout_valid  output  1  holding register contains an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout.
REQ-010 busy  output  1  partial word in progress (bit count nonzero).
REQ-011 overrun  output  1  sticky flag: a word was dropped.
REQ-012 parity_err  output  1  sticky flag: a parity mismatch occurred; tied 0 without the parity macro.

Function
REQ-013 Bits arrive LSB first: the first bit captured after IDLE SHALL appear on dout[0], and the WIDTH-th bit on dout[WIDTH-1].
REQ-014 The shift register SHALL insert each new bit at the MSB end and shift toward the LSB, so no reordering is needed at word completion.
REQ-015 The FSM states SHALL be IDLE (count 0), SHIFT (1..WIDTH-1 bits held), and PARITY (macro only).
REQ-016 IDLE->SHIFT on the first strobed bit; SHIFT->IDLE on the edge capturing data bit WIDTH (no macro); SHIFT->PARITY on that edge (macro).
REQ-017 Word completion SHALL load the holding register and set dout_valid on the same edge; latency is 0 cycles after the edge capturing the last bit.
REQ-018 A transfer SHALL occur on any edge with dout_valid=1 and dout_ready=1; dout_valid clears unless a new word completes on that edge.
REQ-019 While dout_valid=1 and dout_ready=0, dout SHALL remain stable.
REQ-020 Word completion and transfer on the same edge SHALL load the new word, keep dout_valid=1, and leave overrun unchanged.
REQ-021 Word completion while dout_valid=1 and dout_ready=0 SHALL drop the new word, keep the old word, and set overrun.
REQ-022 sin_en=0 SHALL hold the FSM, count, and shift register unchanged; gaps between bits are unlimited.
REQ-023 flush=1 SHALL return the FSM to IDLE and clear the count, shift register, overrun, and parity_err; the holding register and dout_valid are unaffected.
REQ-024 flush SHALL take priority over sin_en on the same edge, and that bit is discarded.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 When clear_n=0 at a rising edge, the FSM SHALL go to IDLE and all of the following SHALL be 0: count, shift register, dout, dout_valid, overrun, and parity_err.
REQ-027 clear_n SHALL take priority over flush, sin_en, and dout_ready.
REQ-028 Reset asserted mid-word or with a pending word SHALL discard all data.
REQ-029 There SHALL be no asynchronous reset path.

Configuration
REQ-030 When macro SIPO_DESER_PARITY_EN is defined, each frame SHALL be WIDTH data bits plus 1 even-parity bit; the word completes on the parity-bit edge (PARITY->IDLE).
REQ-031 With SIPO_DESER_PARITY_EN, a parity mismatch SHALL set parity_err and still deliver the word; overrun rules apply at that completion edge.
REQ-032 Without SIPO_DESER_PARITY_EN, the PARITY state SHALL be absent and parity_err SHALL be constant 0.

Structure
REQ-033 The shared package sipo_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and the WIDTH default and range constants.
REQ-034 One sub-module, sipo_hold_reg, SHALL implement the holding register with the valid/ready/overrun logic; the shifter and FSM SHALL stay in sipo_deser.

Verification
REQ-035 WIDTH=4, reset, then strobe bits 0,1,0,1 -> dout=4'b1010, dout_valid=1 after the 4th edge, busy=0.
REQ-036 Strobe bits 1,1 and sin_en low for 5 cycles, then bits 0,0 -> dout=4'b0011; a pulse of flush after 2 bits -> next 4 bits 1,0,0,1 give 4'b1001.
REQ-037 dout_ready=0, send 4'b1010 then 4'b0110 -> dout stays 4'b1010 and overrun=1; flush clears overrun and dout stays valid.
REQ-038 dout_ready=1 on the same edge a new word 4'b1100 completes -> dout=4'b1100, dout_valid stays 1, overrun=0.
REQ-039 clear_n=0 after 3 of 4 bits with a word pending -> dout=0, dout_valid=0, busy=0 next cycle; then 4 bits 1,1,1,1 -> dout=4'b1111.
REQ-040 With SIPO_DESER_PARITY_EN, send data bits 1,0,1,1 plus parity 0 -> dout=4'b1101 and parity_err=1; with parity 1 -> parity_err stays 0.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg -- shared definitions for the serial-in/parallel-out deserializer.
//   state_t       : FSM encoding (IDLE, SHIFT, PARITY)
//   WIDTH_DEFAULT : default data word width
//   WIDTH_MIN/MAX : legal range of WIDTH
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned WIDTH_MIN     = 2;
  localparam int unsigned WIDTH_MAX     = 32;

endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if -- word output handshake of the deserializer.
//   dout       : deserialized word (master -> slave)
//   dout_valid : holding register contains an unconsumed word (master -> slave)
//   dout_ready : consumer accepts dout (slave -> master)
// Modports: master (deserializer side), slave (consumer side).
interface sipo_deser_if
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg -- output holding register with valid/ready handshake and
// sticky overrun detection.
//   clk        : rising-edge clock
//   clear_n    : synchronous active-low reset
//   flush      : clears the overrun flag (held word is untouched)
//   load       : a completed word is presented on din this cycle
//   din        : completed word
//   ready      : consumer accepts dout
//   dout       : held word
//   dout_valid : held word not yet consumed
//   overrun    : sticky, a completed word was dropped
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic accept;
  logic drop;

  // A new word is taken if the register is empty or drained on this edge.
  assign accept = load && (!dout_valid || ready);
  assign drop   = load && dout_valid && !ready;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        dout       <= din;
        dout_valid <= 1'b1;
      end else if (dout_valid && ready) begin
        dout_valid <= 1'b0;
      end

      if (flush)
        overrun <= 1'b0;
      else if (drop)
        overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in/parallel-out deserializer, LSB first.
//   clk        : rising-edge clock (only clock)
//   clear_n    : synchronous active-low reset
//   sin        : serial data bit, sampled when sin_en=1
//   sin_en     : bit strobe
//   flush      : abort partial word, clear overrun/parity_err
//   busy       : partial word in progress
//   overrun    : sticky, a completed word was dropped
//   parity_err : sticky, parity mismatch (constant 0 without parity)
//   out        : sipo_deser_if.master (dout, dout_valid, dout_ready)
// Parameter WIDTH: data word width, legal range 2..32.
// Macro SIPO_DESER_PARITY_EN: each frame carries one trailing even-parity bit.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         sin,
  input  logic         sin_en,
  input  logic         flush,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err,
  sipo_deser_if.master out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             load;
`ifdef SIPO_DESER_PARITY_EN
  logic             pe_set;
`endif

  // New bit enters at the MSB; after WIDTH bits the first one sits at bit 0.
  assign shifted = {sin, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE;
      count <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sr    <= sr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sr_nxt    = sr;
    load      = 1'b0;
    word      = shifted;
`ifdef SIPO_DESER_PARITY_EN
    pe_set    = 1'b0;
`endif
    if (flush) begin
      state_nxt = IDLE;
      count_nxt = '0;
      sr_nxt    = '0;
    end else if (sin_en) begin
      unique case (state)
        IDLE: begin
          sr_nxt    = shifted;
          count_nxt = CW'(1);
          state_nxt = SHIFT;
        end
        SHIFT: begin
          sr_nxt = shifted;
          if (count == CW'(WIDTH - 1)) begin
`ifdef SIPO_DESER_PARITY_EN
            count_nxt = CW'(WIDTH);
            state_nxt = PARITY;
`else
            count_nxt = '0;
            state_nxt = IDLE;
            load      = 1'b1;
`endif
          end else begin
            count_nxt = count + CW'(1);
          end
        end
`ifdef SIPO_DESER_PARITY_EN
        PARITY: begin
          // Data is already fully aligned in sr; sin is the parity bit.
          word      = sr;
          load      = 1'b1;
          pe_set    = ((^sr) != sin);
          count_nxt = '0;
          state_nxt = IDLE;
        end
`endif
        default: begin
          count_nxt = '0;
          sr_nxt    = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef SIPO_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!clear_n || flush)
      parity_err <= 1'b0;
    else if (pe_set)
      parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .clear_n    (clear_n),
    .flush      (flush),
    .load       (load),
    .din        (word),
    .ready      (out.dout_ready),
    .dout       (out.dout),
    .dout_valid (out.dout_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser -- directed self-checking bench for sipo_deser (WIDTH=4).
// Build with +define+SIPO_DESER_PARITY_EN to exercise the parity frame.
module tb_sipo_deser;

  logic clk;
  logic clear_n;
  logic sin;
  logic sin_en;
  logic flush;
  logic busy;
  logic overrun;
  logic parity_err;

  int unsigned n_cmp;
  int unsigned n_err;

  sipo_deser_if #(.WIDTH(4)) bus ();

  sipo_deser #(
    .WIDTH (4)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .sin        (sin),
    .sin_en     (sin_en),
    .flush      (flush),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err),
    .out        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin    = b;
    sin_en = 1'b1;
    tick();
    sin_en = 1'b0;
  endtask

  // Sends the 4 data bits LSB first, plus the even-parity bit when enabled.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic end_frame(input logic [3:0] w);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(^w);
`else
    if (w === 4'bxxxx) $display("bad frame word");
`endif
  endtask

  task automatic consume();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_n = 1'b0;
    sin = 1'b0;
    sin_en = 1'b0;
    flush = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_valid", 32'(bus.dout_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_parity", 32'(parity_err), 32'h0);
    clear_n = 1'b1;

    // 0,1,0,1 -> 4'b1010
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("w1_busy_mid", 32'(busy), 32'h1);
    check("w1_valid_mid", 32'(bus.dout_valid), 32'h0);
    send_bit(1'b1);
    end_frame(4'b1010);
    check("w1_dout", 32'(bus.dout), 32'ha);
    check("w1_valid", 32'(bus.dout_valid), 32'h1);
    check("w1_busy", 32'(busy), 32'h0);
    consume();
    check("w1_drained", 32'(bus.dout_valid), 32'h0);

    // gap of 5 idle strobes inside the word -> 4'b0011
    send_bit(1'b1); send_bit(1'b1);
    sin = 1'b0;
    repeat (5) tick();
    check("gap_busy", 32'(busy), 32'h1);
    check("gap_valid", 32'(bus.dout_valid), 32'h0);
    send_bit(1'b0); send_bit(1'b0);
    end_frame(4'b0011);
    check("gap_dout", 32'(bus.dout), 32'h3);
    check("gap_valid2", 32'(bus.dout_valid), 32'h1);
    consume();

    // flush after 2 bits, with a strobed bit on the flush edge discarded
    send_bit(1'b1); send_bit(1'b1);
    flush = 1'b1; sin = 1'b1; sin_en = 1'b1;
    tick();
    flush = 1'b0; sin_en = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    end_frame(4'b1001);
    check("flush_dout", 32'(bus.dout), 32'h9);
    consume();

    // overrun: 1010 held, 0110 dropped
    send_word(4'b1010);
    repeat (3) tick();
    check("hold_stable", 32'(bus.dout), 32'ha);
    send_word(4'b0110);
    check("ovr_dout", 32'(bus.dout), 32'ha);
    check("ovr_valid", 32'(bus.dout_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovr_flushed", 32'(overrun), 32'h0);
    check("ovr_keep_valid", 32'(bus.dout_valid), 32'h1);
    check("ovr_keep_dout", 32'(bus.dout), 32'ha);

    // completion and transfer on the same edge -> 4'b1100 replaces 4'b1010
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
`ifdef SIPO_DESER_PARITY_EN
    send_bit(1'b1);
    bus.dout_ready = 1'b1;
    send_bit(1'b0);
`else
    bus.dout_ready = 1'b1;
    send_bit(1'b1);
`endif
    check("same_dout", 32'(bus.dout), 32'hc);
    check("same_valid", 32'(bus.dout_valid), 32'h1);
    check("same_overrun", 32'(overrun), 32'h0);
    tick();
    bus.dout_ready = 1'b0;
    check("same_drained", 32'(bus.dout_valid), 32'h0);

    // reset mid-word with a word pending; reset beats flush/sin_en/ready
    send_word(4'b1010);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    clear_n = 1'b0; flush = 1'b1; sin = 1'b1; sin_en = 1'b1; bus.dout_ready = 1'b1;
    tick();
    clear_n = 1'b1; flush = 1'b0; sin_en = 1'b0; bus.dout_ready = 1'b0;
    check("mid_rst_dout", 32'(bus.dout), 32'h0);
    check("mid_rst_valid", 32'(bus.dout_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    send_word(4'b1111);
    check("post_rst_dout", 32'(bus.dout), 32'hf);
    check("post_rst_valid", 32'(bus.dout_valid), 32'h1);
    check("parity_flag", 32'(parity_err), 32'h0);
    consume();

`ifdef SIPO_DESER_PARITY_EN
    // 1,0,1,1 has three ones: even parity bit must be 1
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("par_wait_busy", 32'(busy), 32'h1);
    check("par_wait_valid", 32'(bus.dout_valid), 32'h0);
    send_bit(1'b0);
    check("par_bad_dout", 32'(bus.dout), 32'hd);
    check("par_bad_err", 32'(parity_err), 32'h1);
    check("par_bad_busy", 32'(busy), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("par_flush", 32'(parity_err), 32'h0);
    consume();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);
    check("par_ok_dout", 32'(bus.dout), 32'hd);
    check("par_ok_err", 32'(parity_err), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
